product_accumulator: RTL and testbench
======================================

# product_accumulator

Sequential accumulator directly downstream of the 16×4 partial-product multiplier in the DNN datapath. Consumes one unsigned 20-bit product per accepted handshake and sums LEN products, one neuron dot-product window. Presents the saturated sum on a valid/ready output port. An optional approximate mode truncates low product bits before accumulation to cut adder width and activity.

## Interface
- PROD_W, 20, width of incoming product (matches 16×4 multiplier output)
- ACC_W, 24, accumulator/result width; must be ≥ PROD_W
- LEN, 16, products per result window; range 1..256
- TRUNC_BITS, 4, low product bits zeroed when APPROX_TRUNC_EN is defined; must be < PROD_W
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  product m is valid this cycle
- in_ready  output  1  block can accept a product
- m  input  PROD_W  unsigned product from multiplier
- out_valid  output  1  acc holds a finished window sum
- out_ready  input  1  consumer takes acc
- acc  output  ACC_W  window sum, saturated
- sat  output  1  window saturated at least once; qualified by out_valid

## Operation
- States: ACCUM, HOLD. Reset state: ACCUM.
- Transfer on input: in_valid & in_ready at clk edge. Transfer on output: out_valid & out_ready.
- ACCUM:
  - in_ready=1 and out_valid=0.
  - Each input transfer sets sum ← sat_add(sum, p), where p = m (exact) or m with low TRUNC_BITS zeroed (approx).
  - Each input transfer increments cnt.
  - On the transfer with cnt==LEN-1, the final sum is written to acc and the sticky flag to sat. Then cnt←0, sum←0, state→HOLD.
- HOLD:
  - in_ready=0 and out_valid=1. acc and sat are held stable.
  - in_valid is ignored; no product is consumed.
  - Output transfer returns the block to ACCUM.
- Arithmetic:
  - p is zero-extended to ACC_W.
  - If sum+p ≥ 2^ACC_W, the result is clamped to 2^ACC_W-1 and the sticky sat_int is set.
  - sat_int clears at window start.
- Gaps: in_valid low in ACCUM leaves sum and cnt unchanged. Bubbles are allowed anywhere inside a window.
- LEN=1: every accepted product goes straight to HOLD.
- Reset (any state, mid-window included):
  - state=ACCUM, cnt=0, sum=0, sat_int=0.
  - acc=0, sat=0, out_valid=0. in_ready=1 the first cycle after reset deasserts.
  - A partial window is discarded.

## Timing
- in_ready and out_valid are decoded from registered state only, with no combinational path from in_valid or out_ready.
- acc and sat are registered.
- Latency: out_valid rises on the edge that accepts the LEN-th product and is visible the cycle after that transfer.
- Peak throughput is one result per LEN+1 cycles: LEN accept cycles plus at least one HOLD cycle.
- The first product of the next window can be accepted the cycle after the output transfer.
- Backpressure holds HOLD indefinitely with acc stable. in_ready stays 0 throughout.

## Configuration
- APPROX_TRUNC_EN defined: p = {m[PROD_W-1:TRUNC_BITS], TRUNC_BITS'b0}. The low TRUNC_BITS adder bits are constant zero and are allowed to be optimised away.
- APPROX_TRUNC_EN undefined: p = m exactly. TRUNC_BITS is unused.

## Structure
- Shared package prod_acc_pkg holds:
  - state enum {ACCUM, HOLD}
  - default PROD_W/ACC_W/LEN/TRUNC_BITS constants
  - counter width function clog2(LEN)
- One sub-module, sat_add (ACC_W-bit unsigned saturating adder, outputs sum and overflow). The FSM, counter and truncation live in product_accumulator.

## Test plan
- Exact mode, defaults: 16 back-to-back products of 0xE102D (0xF003×0xF) -> out_valid the cycle after the 16th transfer, acc=0xE102D0, sat=0.
- APPROX_TRUNC_EN, TRUNC_BITS=4: same stimulus -> acc=0xE10200, sat=0.
- ACC_W=22: 16 × 0xE102D -> acc=0x3FFFFF, sat=1. Following window of 16 × 0x1 -> acc=0x10, sat=0.
- Backpressure: hold out_ready=0 for 10 cycles while in_valid=1 with m=0xFFFFF -> in_ready=0, acc stable, no products consumed. Next window sums correctly after release.
- Bubbles: 16 products of 0x00001 with in_valid toggled every other cycle -> acc=0x10 after the 16th accepted product only.
- Reset mid-window: 7 products of 0x12345, then rst_n=0 for one cycle, then 16 × 0x00002 -> acc=0x20, out_valid=0 during and right after reset.

Source files
------------

// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the product accumulator: FSM state type, default
// geometry constants and the counter-width helper.
// No ports; imported by product_accumulator and sat_add.
package prod_acc_pkg;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_e;

   localparam int PROD_W_DEF     = 20;
   localparam int ACC_W_DEF      = 24;
   localparam int LEN_DEF        = 16;
   localparam int TRUNC_BITS_DEF = 4;

   // Bits needed to count 0..n-1; never less than one so LEN=1 still
   // yields a legal counter.
   function automatic int clog2(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) begin
         w = w + 1;
      end
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/product_accumulator_sat_add.sv
// Unsigned W-bit saturating adder, purely combinational (zero latency).
// Ports: a, b (addends), sum (clamped to all-ones on carry-out), ovf (carry-out).
// No flow control; the caller decides when the result is used.
module sat_add
   import prod_acc_pkg::*;
#(
   parameter int W = ACC_W_DEF
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         ovf
);

   logic [W:0] full;

   always_comb begin
      full = {1'b0, a} + {1'b0, b};
      ovf  = full[W];
      sum  = full[W] ? {W{1'b1}} : full[W-1:0];
   end

endmodule

// File: rtl/product_accumulator.sv
// Sums LEN unsigned products per window with saturation and presents the
// result on a valid/ready port; out_valid is seen the cycle after the LEN-th
// accepted product. While a result waits (HOLD) in_ready is 0 and acc/sat are
// held, so output backpressure stalls the input side indefinitely.
// Ports: clk, rst_n (sync, active low), in_valid/in_ready/m (product input),
//        out_valid/out_ready/acc/sat (window result; sat qualified by out_valid).
// Build option: define APPROX_TRUNC_EN to zero the low TRUNC_BITS of each
// product before accumulation.
module product_accumulator
   import prod_acc_pkg::*;
#(
   parameter int PROD_W     = PROD_W_DEF,
   parameter int ACC_W      = ACC_W_DEF,
   parameter int LEN        = LEN_DEF,
   parameter int TRUNC_BITS = TRUNC_BITS_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] m,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  acc,
   output logic              sat
);

   localparam int CNT_W = clog2(LEN);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ACC_W-1:0]   sum_q, sum_d;
   logic               sat_int_q, sat_int_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic               sat_q, sat_d;

   logic [ACC_W-1:0]   p_ext;
   logic [ACC_W-1:0]   add_sum;
   logic               add_ovf;
   logic               sat_win;
   logic               in_xfer;

   // Handshake outputs come straight from the registered state.
   assign in_ready  = (state_q == ACCUM);
   assign out_valid = (state_q == HOLD);
   assign acc       = acc_q;
   assign sat       = sat_q;
   assign in_xfer   = in_valid & in_ready;

`ifdef APPROX_TRUNC_EN
   logic [PROD_W-1:0] trunc_mask;
   assign trunc_mask = {PROD_W{1'b1}} << TRUNC_BITS;
   assign p_ext      = ACC_W'(m & trunc_mask);
`else
   assign p_ext      = ACC_W'(m);
`endif

   sat_add #(.W(ACC_W)) u_sat_add (
      .a   (sum_q),
      .b   (p_ext),
      .sum (add_sum),
      .ovf (add_ovf)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sum_d     = sum_q;
      sat_int_d = sat_int_q;
      acc_d     = acc_q;
      sat_d     = sat_q;
      sat_win   = sat_int_q | add_ovf;

      case (state_q)
         ACCUM: begin
            if (in_xfer) begin
               if (cnt_q == CNT_W'(LEN - 1)) begin
                  // Last product: publish the result and re-arm the window
                  // state so the next window starts clean.
                  acc_d     = add_sum;
                  sat_d     = sat_win;
                  cnt_d     = '0;
                  sum_d     = '0;
                  sat_int_d = 1'b0;
                  state_d   = HOLD;
               end else begin
                  sum_d     = add_sum;
                  sat_int_d = sat_win;
                  cnt_d     = cnt_q + CNT_W'(1);
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d = ACCUM;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ACCUM;
         cnt_q     <= '0;
         sum_q     <= '0;
         sat_int_q <= 1'b0;
         acc_q     <= '0;
         sat_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sum_q     <= sum_d;
         sat_int_q <= sat_int_d;
         acc_q     <= acc_d;
         sat_q     <= sat_d;
      end
   end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: a 24-bit and a 22-bit instance share one
// input stream; a window-sum model predicts handshakes and results each cycle.
module tb_product_accumulator;

   localparam int LEN = 16;
   localparam longint MAX24 = (64'd1 << 24) - 1;
   localparam longint MAX22 = (64'd1 << 22) - 1;

`ifdef APPROX_TRUNC_EN
   localparam logic [31:0] E_E102D_24 = 32'hE10200;
   localparam logic [31:0] E_ONE16    = 32'h0;
   localparam logic [31:0] E_FFFFF_24 = 32'hFFFF00;
   localparam logic [31:0] E_13X16    = 32'h100;
   localparam logic [31:0] E_TWO16    = 32'h0;
`else
   localparam logic [31:0] E_E102D_24 = 32'hE102D0;
   localparam logic [31:0] E_ONE16    = 32'h10;
   localparam logic [31:0] E_FFFFF_24 = 32'hFFFFF0;
   localparam logic [31:0] E_13X16    = 32'h130;
   localparam logic [31:0] E_TWO16    = 32'h20;
`endif

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [19:0] m;
   logic        out_ready;

   logic        in_ready24, out_valid24, sat24;
   logic [23:0] acc24;
   logic        in_ready22, out_valid22, sat22;
   logic [21:0] acc22;

   int tests;
   int fails;

   product_accumulator #(.PROD_W(20), .ACC_W(24), .LEN(LEN), .TRUNC_BITS(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready24),
      .m(m), .out_valid(out_valid24), .out_ready(out_ready),
      .acc(acc24), .sat(sat24)
   );

   product_accumulator #(.PROD_W(20), .ACC_W(22), .LEN(LEN), .TRUNC_BITS(4)) dut22 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready22),
      .m(m), .out_valid(out_valid22), .out_ready(out_ready),
      .acc(acc22), .sat(sat22)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests = tests + 1;
      if (act !== exp) begin
         fails = fails + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Tracks the running total of the products accepted in the current window;
   // a window result is min(total, 2^W-1), saturated iff total exceeds that.
   bit     armed;
   bit     m_hold;
   int     m_cnt;
   longint m_tot;
   longint m_acc24, m_acc22;
   bit     m_sat24, m_sat22;

   function automatic longint eff_p(input logic [19:0] v);
`ifdef APPROX_TRUNC_EN
      return longint'({v[19:4], 4'b0000});
`else
      return longint'(v);
`endif
   endfunction

   initial begin
      armed = 0;
      m_hold = 0;
      m_cnt = 0;
      m_tot = 0;
      m_acc24 = 0;
      m_acc22 = 0;
      m_sat24 = 0;
      m_sat22 = 0;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            armed = 1;
            m_hold = 0;
            m_cnt = 0;
            m_tot = 0;
            m_acc24 = 0;
            m_acc22 = 0;
            m_sat24 = 0;
            m_sat22 = 0;
         end else if (armed) begin
            if (m_hold) begin
               if (out_ready) m_hold = 0;
            end else if (in_valid) begin
               m_tot = m_tot + eff_p(m);
               m_cnt = m_cnt + 1;
               if (m_cnt == LEN) begin
                  m_acc24 = (m_tot > MAX24) ? MAX24 : m_tot;
                  m_sat24 = (m_tot > MAX24);
                  m_acc22 = (m_tot > MAX22) ? MAX22 : m_tot;
                  m_sat22 = (m_tot > MAX22);
                  m_hold = 1;
                  m_cnt = 0;
                  m_tot = 0;
               end
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (armed) begin
            check("in_ready24",  32'(in_ready24),  32'(!m_hold));
            check("out_valid24", 32'(out_valid24), 32'(m_hold));
            check("in_ready22",  32'(in_ready22),  32'(!m_hold));
            check("out_valid22", 32'(out_valid22), 32'(m_hold));
            check("acc24", 32'(acc24), 32'(m_acc24));
            check("acc22", 32'(acc22), 32'(m_acc22));
            if (m_hold) begin
               check("sat24", 32'(sat24), 32'(m_sat24));
               check("sat22", 32'(sat22), 32'(m_sat22));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic push(input logic [19:0] v);
      bit ok;
      int t;
      t = 0;
      in_valid = 1'b1;
      m = v;
      do begin
         ok = in_ready24;
         tick();
         t = t + 1;
      end while (!ok && t < 50);
      if (!ok) check("push_timeout", 32'(0), 32'(1));
      in_valid = 1'b0;
   endtask

   task automatic push_n(input logic [19:0] v, input int n);
      for (int i = 0; i < n; i++) push(v);
   endtask

   task automatic wait_out(input string name, input logic [31:0] e24, input logic [31:0] s24,
                           input logic [31:0] e22, input logic [31:0] s22);
      bit ok;
      int t;
      t = 0;
      ok = out_valid24;
      while (!ok && t < 50) begin
         tick();
         t = t + 1;
         ok = out_valid24;
      end
      if (!ok) begin
         check({name, "_timeout"}, 32'(0), 32'(1));
      end else begin
         check({name, "_acc24"}, 32'(acc24), e24);
         check({name, "_sat24"}, 32'(sat24), s24);
         check({name, "_acc22"}, 32'(acc22), e22);
         check({name, "_sat22"}, 32'(sat22), s22);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      m = '0;
      out_ready = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      check("rst_in_ready",  32'(in_ready24),  32'(1));
      check("rst_out_valid", 32'(out_valid24), 32'(0));
      check("rst_acc",       32'(acc24),       32'(0));
      check("rst_sat",       32'(sat24),       32'(0));

      // Back-to-back window; result visible right after the 16th transfer.
      push_n(20'hE102D, LEN);
      check("latency_out_valid", 32'(out_valid24), 32'(1));
      wait_out("e102d", E_E102D_24, 32'(0), 32'h3FFFFF, 32'(1));

      // Sticky saturation must not leak into the following window.
      push_n(20'h00001, LEN);
      wait_out("ones", E_ONE16, 32'(0), E_ONE16, 32'(0));

      // Backpressure: result held, inputs refused while in_valid stays high.
      push_n(20'hFFFFF, LEN);
      in_valid = 1'b1;
      m = 20'hFFFFF;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_in_ready", 32'(in_ready24), 32'(0));
         check("bp_acc",      32'(acc24),      E_FFFFF_24);
      end
      in_valid = 1'b0;
      wait_out("bp", E_FFFFF_24, 32'(0), 32'h3FFFFF, 32'(1));
      push_n(20'h00013, LEN);
      wait_out("after_bp", E_13X16, 32'(0), E_13X16, 32'(0));

      // Bubbles between every product.
      for (int i = 0; i < LEN; i++) begin
         push(20'h00001);
         if (i == LEN - 2) check("bubble_early_valid", 32'(out_valid24), 32'(0));
         tick();
      end
      wait_out("bubble", E_ONE16, 32'(0), E_ONE16, 32'(0));

      // Reset in the middle of a window discards the partial sum.
      push_n(20'h12345, 7);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrst_out_valid", 32'(out_valid24), 32'(0));
      check("midrst_in_ready",  32'(in_ready24),  32'(1));
      check("midrst_acc",       32'(acc24),       32'(0));
      tick();
      check("midrst_out_valid2", 32'(out_valid24), 32'(0));
      push_n(20'h00002, LEN);
      wait_out("after_rst", E_TWO16, 32'(0), E_TWO16, 32'(0));

      tick();
      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
